// File: rtl/fir_decim_avg_fifo.sv
// Decimating boxcar averager for the FIR output stream. Each group of DECIM valid
// samples becomes one averaged sample, which waits in a first-word-fall-through FIFO.
module fir_decim_avg_fifo #(
  parameter int WIDTH_DATA      = 8,
  parameter int DECIM           = 4,
  parameter int LOG2_DECIM      = 2,
  parameter int FIFO_DEPTH      = 8,
  parameter int LOG2_FIFO_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH_DATA-1:0]      din,
  input  logic                       din_valid,
  output logic [WIDTH_DATA-1:0]      dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [LOG2_FIFO_DEPTH:0]   fill,
  output logic                       overflow
);

  localparam int ACC_W = WIDTH_DATA + LOG2_DECIM;

  logic [LOG2_DECIM-1:0]       phase_reg;
  logic signed [ACC_W-1:0]     acc_reg;
  logic signed [ACC_W-1:0]     din_ext;
  logic signed [ACC_W-1:0]     acc_base;
  logic signed [ACC_W-1:0]     sum;
  logic signed [ACC_W-1:0]     avg_wide;
  logic [WIDTH_DATA-1:0]       avg;
  logic                        last_phase;

  logic [WIDTH_DATA-1:0]       mem [FIFO_DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0]  rd_ptr_reg;
  logic [LOG2_FIFO_DEPTH-1:0]  wr_ptr_reg;
  logic [LOG2_FIFO_DEPTH:0]    fill_reg;
  logic [LOG2_FIFO_DEPTH:0]    fill_next;
  logic                        overflow_reg;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        accept;

  // The accumulator is at most DECIM samples wide, so ACC_W bits never overflow.
  assign din_ext    = {{LOG2_DECIM{din[WIDTH_DATA-1]}}, din};
  assign acc_base   = (phase_reg == '0) ? '0 : acc_reg;
  assign sum        = acc_base + din_ext;
  assign avg_wide   = sum >>> LOG2_DECIM;
  assign avg        = avg_wide[WIDTH_DATA-1:0];
  assign last_phase = (phase_reg == LOG2_DECIM'(DECIM - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg <= '0;
      acc_reg   <= '0;
    end else if (din_valid) begin
      if (last_phase) begin
        phase_reg <= '0;
        acc_reg   <= '0;
      end else begin
        phase_reg <= phase_reg + LOG2_DECIM'(1);
        acc_reg   <= sum;
      end
    end
  end

  assign push       = din_valid && last_phase;
  assign dout_valid = (fill_reg != '0);
  assign pop        = dout_valid && dout_ready;
  assign full       = (fill_reg == (LOG2_FIFO_DEPTH+1)'(FIFO_DEPTH));
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept     = push && (!full || pop);

  always_comb begin
    fill_next = fill_reg;
    case ({accept, pop})
      2'b10:   fill_next = fill_reg + (LOG2_FIFO_DEPTH+1)'(1);
      2'b01:   fill_next = fill_reg - (LOG2_FIFO_DEPTH+1)'(1);
      default: fill_next = fill_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      fill_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      fill_reg <= fill_next;
      if (accept) wr_ptr_reg <= wr_ptr_reg + LOG2_FIFO_DEPTH'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + LOG2_FIFO_DEPTH'(1);
      if (push && !accept) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= avg;
  end

  assign dout     = dout_valid ? mem[rd_ptr_reg] : '0;
  assign fill     = fill_reg;
  assign overflow = overflow_reg;

endmodule
